// File: rtl/qr_codeword_reader.sv
// Version-1 QR codeword reader: captures a 21x21 module matrix, decodes the format
// information, then walks the zigzag data placement emitting 26 unmasked bytes.
module qr_codeword_reader #(
   parameter int CODE_SIZE     = 21,
   parameter int NUM_CODEWORDS = 26
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [CODE_SIZE*CODE_SIZE-1:0] qr_code,
   input  logic                           valid_qr,
   output logic                           busy,
   output logic [1:0]                     ec_level,
   output logic [2:0]                     mask_id,
   output logic                           format_err,
   output logic [7:0]                     codeword_out,
   output logic [4:0]                     codeword_index,
   output logic                           codeword_valid,
   output logic                           done
);

   localparam logic [14:0] FMT_MASK = 15'b101010000010010;

   typedef enum logic [1:0] {S_IDLE, S_FORMAT, S_WALK, S_DONE} state_t;

   state_t r_state;
   state_t w_next_state;

   logic [CODE_SIZE*CODE_SIZE-1:0] r_matrix;
   logic [3:0]  r_pair;
   logic [4:0]  r_row;
   logic        r_side;
   logic [2:0]  r_bit_cnt;
   logic [4:0]  r_cw_cnt;
   logic [7:0]  r_shift;
   logic        r_byte_rdy;

   logic [4:0]  w_col_base;
   logic [4:0]  w_col;
   logic        w_up;
   logic        w_row_end;
   logic        w_last;
   logic        w_func;
   logic        w_mask_hit;
   logic        w_data_bit;
   logic        w_emit;
   logic [14:0] w_copy1;
   logic [14:0] w_copy2;
   logic [1:0]  w_i3;
   logic [1:0]  w_j3;
   logic [2:0]  w_sum;
   logic        w_sum3_zero;
   logic        w_p3_zero;
   logic        w_p3_one;
   logic        w_p2;
   logic        w_s2;

   function automatic logic [8:0] pos(input logic [4:0] r, input logic [4:0] c);
      return 9'(r) * 9'd21 + 9'(c);
   endfunction

   function automatic logic [1:0] mod3(input logic [4:0] v);
      case (v)
         5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15, 5'd18, 5'd21, 5'd24, 5'd27, 5'd30: mod3 = 2'd0;
         5'd1, 5'd4, 5'd7, 5'd10, 5'd13, 5'd16, 5'd19, 5'd22, 5'd25, 5'd28, 5'd31: mod3 = 2'd1;
         default: mod3 = 2'd2;
      endcase
   endfunction

   // Only the parity of j/3 matters to mask 100.
   function automatic logic div3_odd(input logic [4:0] v);
      case (v)
         5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17,
         5'd21, 5'd22, 5'd23, 5'd27, 5'd28, 5'd29: div3_odd = 1'b1;
         default: div3_odd = 1'b0;
      endcase
   endfunction

   assign w_copy1 = FMT_MASK ^ {
      r_matrix[pos(5'd8, 5'd0)], r_matrix[pos(5'd8, 5'd1)], r_matrix[pos(5'd8, 5'd2)],
      r_matrix[pos(5'd8, 5'd3)], r_matrix[pos(5'd8, 5'd4)], r_matrix[pos(5'd8, 5'd5)],
      r_matrix[pos(5'd8, 5'd7)], r_matrix[pos(5'd8, 5'd8)], r_matrix[pos(5'd7, 5'd8)],
      r_matrix[pos(5'd5, 5'd8)], r_matrix[pos(5'd4, 5'd8)], r_matrix[pos(5'd3, 5'd8)],
      r_matrix[pos(5'd2, 5'd8)], r_matrix[pos(5'd1, 5'd8)], r_matrix[pos(5'd0, 5'd8)]};

   assign w_copy2 = FMT_MASK ^ {
      r_matrix[pos(5'd20, 5'd8)], r_matrix[pos(5'd19, 5'd8)], r_matrix[pos(5'd18, 5'd8)],
      r_matrix[pos(5'd17, 5'd8)], r_matrix[pos(5'd16, 5'd8)], r_matrix[pos(5'd15, 5'd8)],
      r_matrix[pos(5'd14, 5'd8)], r_matrix[pos(5'd8, 5'd13)], r_matrix[pos(5'd8, 5'd14)],
      r_matrix[pos(5'd8, 5'd15)], r_matrix[pos(5'd8, 5'd16)], r_matrix[pos(5'd8, 5'd17)],
      r_matrix[pos(5'd8, 5'd18)], r_matrix[pos(5'd8, 5'd19)], r_matrix[pos(5'd8, 5'd20)]};

   // Column pairs left of the vertical timing column sit one column further left.
   assign w_col_base = (r_pair < 4'd7) ? 5'd20 - {r_pair, 1'b0} : 5'd19 - {r_pair, 1'b0};
   assign w_col      = w_col_base - {4'd0, r_side};
   assign w_up       = ~r_pair[0];
   assign w_row_end  = w_up ? (r_row == 5'd0) : (r_row == 5'd20);
   assign w_last     = (r_pair == 4'd9) && w_row_end && r_side;

   assign w_func = ((r_row <= 5'd8) && (w_col <= 5'd8))  ||
                   ((r_row <= 5'd8) && (w_col >= 5'd13)) ||
                   ((r_row >= 5'd13) && (w_col <= 5'd8)) ||
                   (r_row == 5'd6);

   assign w_i3        = mod3(r_row);
   assign w_j3        = mod3(w_col);
   assign w_sum       = {1'b0, w_i3} + {1'b0, w_j3};
   assign w_sum3_zero = (w_sum == 3'd0) || (w_sum == 3'd3);
   assign w_p3_zero   = (w_i3 == 2'd0) || (w_j3 == 2'd0);
   assign w_p3_one    = !w_p3_zero && (w_i3 == w_j3);
   assign w_p2        = r_row[0] & w_col[0];
   assign w_s2        = r_row[0] ^ w_col[0];

   always_comb begin
      case (mask_id)
         3'd0:    w_mask_hit = ~w_s2;
         3'd1:    w_mask_hit = ~r_row[0];
         3'd2:    w_mask_hit = (w_j3 == 2'd0);
         3'd3:    w_mask_hit = w_sum3_zero;
         3'd4:    w_mask_hit = ~(r_row[1] ^ div3_odd(w_col));
         3'd5:    w_mask_hit = ~w_p2 & w_p3_zero;
         3'd6:    w_mask_hit = ~(w_p2 ^ w_p3_one);
         default: w_mask_hit = ~(w_s2 ^ w_p3_one);
      endcase
   end

   assign w_data_bit = r_matrix[pos(r_row, w_col)] ^ w_mask_hit;
   assign w_emit     = r_byte_rdy && (r_cw_cnt < 5'(NUM_CODEWORDS));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (valid_qr) w_next_state = S_FORMAT;
         S_FORMAT: w_next_state = S_WALK;
         S_WALK:   if (w_last) w_next_state = S_DONE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_in) begin
      if (rst_in) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: the matrix register is cleared on reset too, so a reset leaves no stale symbol.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_matrix       <= '0;
         r_pair         <= '0;
         r_row          <= '0;
         r_side         <= 1'b0;
         r_bit_cnt      <= '0;
         r_cw_cnt       <= '0;
         r_shift        <= '0;
         r_byte_rdy     <= 1'b0;
         busy           <= 1'b0;
         ec_level       <= '0;
         mask_id        <= '0;
         format_err     <= 1'b0;
         codeword_out   <= '0;
         codeword_index <= '0;
         codeword_valid <= 1'b0;
         done           <= 1'b0;
      end else begin
         codeword_valid <= 1'b0;
         done           <= 1'b0;
         r_byte_rdy     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (valid_qr) begin
                  r_matrix  <= qr_code;
                  busy      <= 1'b1;
                  r_pair    <= '0;
                  r_row     <= 5'd20;
                  r_side    <= 1'b0;
                  r_bit_cnt <= '0;
                  r_cw_cnt  <= '0;
                  r_shift   <= '0;
               end
            end
            S_FORMAT: begin
               ec_level   <= w_copy1[14:13];
               mask_id    <= w_copy1[12:10];
               format_err <= (w_copy1 != w_copy2);
            end
            S_WALK: begin
               if (!w_func) begin
                  r_shift    <= {r_shift[6:0], w_data_bit};
                  r_bit_cnt  <= r_bit_cnt + 3'd1;
                  r_byte_rdy <= (r_bit_cnt == 3'd7);
               end
               if (!r_side) begin
                  r_side <= 1'b1;
               end else begin
                  r_side <= 1'b0;
                  if (w_row_end) begin
                     if (r_pair != 4'd9) r_pair <= r_pair + 4'd1;
                  end else begin
                     r_row <= w_up ? r_row - 5'd1 : r_row + 5'd1;
                  end
               end
            end
            default: begin
               done <= 1'b1;
               busy <= 1'b0;
            end
         endcase
         if (w_emit) begin
            codeword_out   <= r_shift;
            codeword_index <= r_cw_cnt;
            codeword_valid <= 1'b1;
            r_cw_cnt       <= r_cw_cnt + 5'd1;
         end
      end
   end

endmodule
